uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
// - UART receiver; downstream peer of the transmitter; recovers frames from serial line rxd.
// - Frame: 1 start (0), DATA_BITS data LSB first, optional parity, 1 stop (1); 8x oversampling.
// - Presents one received word with a valid/ack handshake; flags framing, overrun and parity errors.
// PARAMETERS
// - data_bits      8   width of received word
// - clks_per_tick  16  sysclk cycles per oversample tick (tick = 8x baud); >=2
// - tick_cnt_bits  8   width of tick divider counter; must hold clks_per_tick-1
// PORTS
// - sysclk     input   1          system clock, all logic on rising edge
// - rst_n      input   1          asynchronous active-low reset
// - rxd        input   1          serial line, idle high, asynchronous to sysclk
// - rxd_ack    input   1          consumer accepted rdata (1-cycle pulse or level)
// - rdata      output  data_bits  last accepted frame payload
// - rxd_readyH output  1          rdata valid; held until rxd_ack
// - ferr       output  1          stop bit sampled 0 for frame in rdata
// - oerr       output  1          frame completed while rxd_readyH=1; frame dropped
// - perr       output  1          parity mismatch for frame in rdata (0 without UART_RX_PARITY_EN)
// BEHAVIOUR
// - Reset (async, rst_n=0): all outputs 0, FSM IDLE, counters 0, synchroniser flops = 1.
// - rxd passes 2-flop synchroniser -> rxd_s (2 sysclk latency); FSM uses rxd_s only.
// - Tick divider: counts 0..clks_per_tick-1, 1-cycle tick at terminal count; free-running.
// - Sample counter s (3 bit) increments per tick; bit counter b counts data bits.
// - IDLE: on tick with rxd_s=0 -> START, s=0.
// - START: on tick with s=3 re-sample; rxd_s=1 -> IDLE (glitch reject); rxd_s=0 -> DATA, s=0, b=0.
// - DATA: on tick with s=7 (bit centre) shift rxd_s into shreg MSB, shift right; b++;
//   after data_bits-th sample -> PARITY if macro on, else STOP; s=0.
// - PARITY: on tick with s=7 capture parity bit -> STOP.
// - STOP: on tick with s=7 sample stop bit -> DELIVER action same cycle:
//   - rxd_readyH=0 or rxd_ack=1 this cycle: rdata<=shreg, rxd_readyH<=1, ferr<=~stop,
//     perr<=parity fail; oerr unchanged.
//   - rxd_readyH=1 and no rxd_ack: rdata/ferr/perr unchanged, oerr<=1, frame dropped.
//   - stop=1 -> IDLE; stop=0 -> BRKWAIT.
// - BRKWAIT: stay until rxd_s=1, then IDLE (break / stuck-low line never retriggers).
// - rxd_ack with rxd_readyH=1 and no delivery: next cycle rxd_readyH, ferr, perr, oerr = 0.
// - rxd_ack with rxd_readyH=0: ignored.
// - Ack and delivery same cycle: new frame loaded, rxd_readyH stays 1, oerr stays 0.
// - Latency: rxd_readyH rises 1 sysclk after the stop-bit centre tick
//   (~9.5 bit periods + 2 sync cycles after start edge for 8N1).
// - Start alignment error <= 1 tick (1/8 bit); centre sampling gives +/-3/8 bit margin.
// - rxd_ack is not qualified by FSM state; receiving continues while a word is pending.
// CONFIGURATION
// - UART_RX_PARITY_EN defined: PARITY state present; parity bit follows data; even parity:
//   perr=1 when XOR(data, parity bit)=1. Frame is data_bits+3 bits.
// - UART_RX_PARITY_EN undefined: no PARITY state; perr tied 0; frame is data_bits+2 bits.
// TESTING (clks_per_tick=4 -> 32 sysclk per bit, data_bits=8)
// - Frame 0xA5, stop=1
//   -> rdata=8'hA5, rxd_readyH=1, ferr=0, oerr=0, rise 306..310 sysclk after start edge;
//   rxd_ack -> readyH=0 next cycle.
// - rxd low 8 sysclk then high -> no rxd_readyH; FSM back in IDLE; following 0x5A received cleanly.
// - Frame 0x3C, stop=0, line held low 100 bit periods
//   -> rdata=8'h3C, ferr=1; no further frame until line high; then 0x81 received.
// - Frames 0x11 then 0x22, no ack -> rdata=8'h11, oerr=1; rxd_ack clears readyH and oerr.
// - rxd_ack asserted exactly on delivery cycle of 0x55 while 0x11 pending
//   -> rdata=8'h55, readyH=1, oerr=0.
// - rst_n low during bit 3 of a frame -> all outputs 0 immediately;
//   next frame 0x0F -> rdata=8'h0F.
//   With UART_RX_PARITY_EN: 0x07 + parity 1 -> perr=0; + parity 0 -> perr=1.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: UART receiver with 8x oversampling.
// Frame: start bit (0), data_bits data bits LSB first, optional even parity
// bit, one stop bit (1). Received words are presented with a valid/ack
// handshake. Framing, overrun and parity errors are flagged.
//
// Optional feature macro: UART_RX_PARITY_EN (adds the parity bit slot; when
// undefined there is no PARITY state and perr is tied 0).
//
// Ports:
//   sysclk      in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   rxd         in   serial line, idle high, asynchronous to sysclk
//   rxd_ack     in   consumer accepted rdata (pulse or level)
//   rdata       out  payload of the last accepted frame
//   rxd_readyH  out  rdata valid, held until rxd_ack
//   ferr        out  stop bit sampled 0 for the frame in rdata
//   oerr        out  a frame completed while rxd_readyH=1 and was dropped
//   perr        out  parity mismatch for the frame in rdata
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | line idle, waiting for a low sample on a tick
// ST_START   | start bit seen, re-check at its centre (glitch reject)
// ST_DATA    | sampling data bits at their centres
// ST_PARITY  | sampling the parity bit (UART_RX_PARITY_EN only)
// ST_STOP    | sampling the stop bit, then delivering the word
// ST_BRKWAIT | stop bit was low; wait for the line to return high
module uart_rx #(
   parameter int data_bits     = 8,
   parameter int clks_per_tick = 16,
   parameter int tick_cnt_bits = 8
) (
   input  logic                 sysclk,
   input  logic                 rst_n,
   input  logic                 rxd,
   input  logic                 rxd_ack,
   output logic [data_bits-1:0] rdata,
   output logic                 rxd_readyH,
   output logic                 ferr,
   output logic                 oerr,
   output logic                 perr
);

   localparam int BCNT_W = $clog2(data_bits + 1);
   localparam logic [tick_cnt_bits-1:0] TICK_LAST = tick_cnt_bits'(clks_per_tick - 1);
   localparam logic [BCNT_W-1:0]        B_LAST    = BCNT_W'(data_bits - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
      ST_PARITY  = 3'd3,
`endif
      ST_STOP    = 3'd4,
      ST_BRKWAIT = 3'd5
   } state_e;

   state_e                   state_q, state_d;
   logic                     rxd_meta_q, rxd_s_q;
   logic [tick_cnt_bits-1:0] tick_cnt_q;
   logic                     tick;
   logic [2:0]               s_q, s_d;
   logic [BCNT_W-1:0]        b_q, b_d;
   logic [data_bits-1:0]     shreg_q, shreg_d;
   logic                     deliver;
   logic [data_bits-1:0]     rdata_q;
   logic                     ready_q, ferr_q, oerr_q;
   logic                     par_fail;

`ifdef UART_RX_PARITY_EN
   logic par_q, par_d, perr_q;
   assign par_fail = ^{shreg_q, par_q};
   assign perr     = perr_q;
`else
   assign par_fail = 1'b0;
   assign perr     = 1'b0;
`endif

   assign rdata      = rdata_q;
   assign rxd_readyH = ready_q;
   assign ferr       = ferr_q;
   assign oerr       = oerr_q;

   // two-flop synchroniser, idles high so reset does not look like a start bit
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         rxd_meta_q <= 1'b1;
         rxd_s_q    <= 1'b1;
      end else begin
         rxd_meta_q <= rxd;
         rxd_s_q    <= rxd_meta_q;
      end
   end

   // free-running oversample tick divider
   assign tick = (tick_cnt_q == TICK_LAST);

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) tick_cnt_q <= '0;
      else        tick_cnt_q <= tick ? '0 : tick_cnt_q + tick_cnt_bits'(1);
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (tick && !rxd_s_q) state_d = ST_START;
         ST_START:   if (tick && s_q == 3'd3) state_d = rxd_s_q ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
         ST_DATA:    if (tick && s_q == 3'd7 && b_q == B_LAST) state_d = ST_PARITY;
         ST_PARITY:  if (tick && s_q == 3'd7) state_d = ST_STOP;
`else
         ST_DATA:    if (tick && s_q == 3'd7 && b_q == B_LAST) state_d = ST_STOP;
`endif
         ST_STOP:    if (tick && s_q == 3'd7) state_d = rxd_s_q ? ST_IDLE : ST_BRKWAIT;
         ST_BRKWAIT: if (rxd_s_q) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // sample counter wraps 7->0 on its own, so bit slots need no explicit clear
   always_comb begin
      s_d     = tick ? s_q + 3'd1 : s_q;
      b_d     = b_q;
      shreg_d = shreg_q;
      deliver = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         ST_IDLE: begin
            s_d = 3'd0;
            b_d = '0;
         end
         ST_START: begin
            b_d = '0;
            if (tick && s_q == 3'd3) s_d = 3'd0;
         end
         ST_DATA: begin
            if (tick && s_q == 3'd7) begin
               shreg_d = {rxd_s_q, shreg_q[data_bits-1:1]};
               b_d     = b_q + BCNT_W'(1);
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (tick && s_q == 3'd7) par_d = rxd_s_q;
         end
`endif
         ST_STOP: begin
            if (tick && s_q == 3'd7) deliver = 1'b1;
         end
         ST_BRKWAIT: s_d = 3'd0;
         default:    s_d = 3'd0;
      endcase
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         s_q     <= 3'd0;
         b_q     <= '0;
         shreg_q <= '0;
`ifdef UART_RX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         s_q     <= s_d;
         b_q     <= b_d;
         shreg_q <= shreg_d;
`ifdef UART_RX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   // A delivery with a same-cycle ack replaces the pending word; without the
   // ack the new frame is dropped and oerr is raised instead.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
         ready_q <= 1'b0;
         ferr_q  <= 1'b0;
         oerr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else if (deliver) begin
         if (!ready_q || rxd_ack) begin
            rdata_q <= shreg_q;
            ready_q <= 1'b1;
            ferr_q  <= ~rxd_s_q;
`ifdef UART_RX_PARITY_EN
            perr_q  <= par_fail;
`endif
         end else begin
            oerr_q <= 1'b1;
         end
      end else if (rxd_ack && ready_q) begin
         ready_q <= 1'b0;
         ferr_q  <= 1'b0;
         oerr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: clks_per_tick=4 (32 sysclk per bit), data_bits=8.
module tb_uart_rx;

   localparam int BIT = 32;
`ifdef UART_RX_PARITY_EN
   localparam int NPAR = 1;
`else
   localparam int NPAR = 0;
`endif
   localparam int LAT_LO = 306 + BIT * NPAR;
   localparam int LAT_HI = 310 + BIT * NPAR;

   logic       sysclk = 1'b0;
   logic       rst_n, rxd, rxd_ack;
   logic [7:0] rdata;
   logic       rxd_readyH, ferr, oerr, perr;

   uart_rx #(.data_bits(8), .clks_per_tick(4), .tick_cnt_bits(8)) dut (
      .sysclk(sysclk), .rst_n(rst_n), .rxd(rxd), .rxd_ack(rxd_ack),
      .rdata(rdata), .rxd_readyH(rxd_readyH), .ferr(ferr), .oerr(oerr), .perr(perr)
   );

   always #5 sysclk = ~sysclk;

   int cyc = 0;
   always @(posedge sysclk) cyc <= cyc + 1;

   // rising-edge monitor for rxd_readyH, sampled away from the active edge
   int   n_rise = 0;
   int   last_rise = 0;
   logic rdy_prev = 1'b0;
   always @(negedge sysclk) begin
      if (rxd_readyH && !rdy_prev) begin
         n_rise    = n_rise + 1;
         last_rise = cyc;
      end
      rdy_prev = rxd_readyH;
   end

   int   n_pass = 0;
   int   n_total = 0;
   int   start_cyc = 0;
   logic started = 1'b0;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         hold_bits;
      logic [7:0] exp_rdata;
      logic       exp_ferr;
   } vec_t;
   vec_t vecs[5];

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic check_rng(input string name, input int act, input int lo, input int hi);
      n_total++;
      if (act >= lo && act <= hi) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic par, input bit align);
      @(negedge sysclk);
      if (align) while (cyc % 4 != 0) @(negedge sysclk);
      rxd       = 1'b0;
      start_cyc = cyc;
      started   = 1'b1;
      repeat (BIT) @(negedge sysclk);
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         repeat (BIT) @(negedge sysclk);
      end
      if (NPAR == 1) begin
         rxd = par;
         repeat (BIT) @(negedge sysclk);
      end
      rxd = stop;
      repeat (BIT) @(negedge sysclk);
   endtask

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(negedge sysclk);
   endtask

   task automatic rx_frame(input logic [7:0] d, input logic stop, input int hold_bits);
      send_frame(d, stop, ^d, 1'b1);
      repeat (hold_bits * BIT) @(negedge sysclk);
      idle(2 * BIT);
   endtask

   task automatic ack_pulse();
      @(negedge sysclk);
      rxd_ack = 1'b1;
      @(negedge sysclk);
      rxd_ack = 1'b0;
   endtask

   int         nr, lat;
   logic [7:0] rd;
   logic       rstop, perrbit;
   logic       m_ready, m_ferr, m_oerr, m_perr;
   logic [7:0] m_rdata;

   initial begin
      vecs[0] = '{8'hA5, 1'b1, 0,   8'hA5, 1'b0};
      vecs[1] = '{8'h00, 1'b1, 0,   8'h00, 1'b0};
      vecs[2] = '{8'hFF, 1'b1, 0,   8'hFF, 1'b0};
      vecs[3] = '{8'h3C, 1'b0, 100, 8'h3C, 1'b1};
      vecs[4] = '{8'h81, 1'b1, 0,   8'h81, 1'b0};

      rst_n = 1'b0; rxd = 1'b1; rxd_ack = 1'b0;
      repeat (5) @(negedge sysclk);
      check("reset rdata", rdata, 0);
      check("reset readyH", rxd_readyH, 0);
      check("reset ferr", ferr, 0);
      check("reset oerr", oerr, 0);
      check("reset perr", perr, 0);
      rst_n = 1'b1;
      idle(2 * BIT);

      // table-driven frames, each acknowledged
      for (int i = 0; i < 5; i++) begin
         nr = n_rise;
         rx_frame(vecs[i].data, vecs[i].stop, vecs[i].hold_bits);
         check("vec rise count", n_rise, nr + 1);
         check_rng("vec latency", last_rise - start_cyc, LAT_LO, LAT_HI);
         check("vec rdata", rdata, vecs[i].exp_rdata);
         check("vec readyH", rxd_readyH, 1);
         check("vec ferr", ferr, vecs[i].exp_ferr);
         check("vec oerr", oerr, 0);
         check("vec perr", perr, 0);
         ack_pulse();
         check("vec ack readyH", rxd_readyH, 0);
         check("vec ack ferr", ferr, 0);
      end

      // 8-cycle glitch must be rejected, then a clean frame
      nr = n_rise;
      @(negedge sysclk);
      rxd = 1'b0;
      repeat (8) @(negedge sysclk);
      idle(3 * BIT);
      check("glitch rise count", n_rise, nr);
      check("glitch readyH", rxd_readyH, 0);
      rx_frame(8'h5A, 1'b1, 0);
      check("post-glitch rdata", rdata, 8'h5A);
      check("post-glitch readyH", rxd_readyH, 1);
      check("post-glitch ferr", ferr, 0);
      ack_pulse();

      // overrun: second frame dropped while first pending
      rx_frame(8'h11, 1'b1, 0);
      rx_frame(8'h22, 1'b1, 0);
      check("overrun rdata", rdata, 8'h11);
      check("overrun readyH", rxd_readyH, 1);
      check("overrun oerr", oerr, 1);
      ack_pulse();
      check("overrun ack readyH", rxd_readyH, 0);
      check("overrun ack oerr", oerr, 0);

      // ack on the exact delivery cycle of the next frame
      rx_frame(8'h11, 1'b1, 0);
      lat = last_rise - start_cyc;
      check_rng("pend latency", lat, LAT_LO, LAT_HI);
      check("pend rdata", rdata, 8'h11);
      if (lat < 2) lat = 2;
      started = 1'b0;
      fork
         send_frame(8'h55, 1'b1, ^8'h55, 1'b1);
         begin
            wait (started);
            repeat (lat - 1) @(negedge sysclk);
            rxd_ack = 1'b1;
            @(negedge sysclk);
            rxd_ack = 1'b0;
         end
      join
      idle(2 * BIT);
      check("ack-deliver rdata", rdata, 8'h55);
      check("ack-deliver readyH", rxd_readyH, 1);
      check("ack-deliver oerr", oerr, 0);

      // async reset during bit 3 of a frame, word 0x55 pending
      @(negedge sysclk);
      rd = 8'hC3;
      rxd = 1'b0;
      repeat (BIT) @(negedge sysclk);
      for (int i = 0; i < 3; i++) begin
         rxd = rd[i];
         repeat (BIT) @(negedge sysclk);
      end
      rxd = rd[3];
      repeat (16) @(negedge sysclk);
      #2 rst_n = 1'b0;
      #1;
      check("midreset rdata", rdata, 0);
      check("midreset readyH", rxd_readyH, 0);
      check("midreset ferr", ferr, 0);
      check("midreset oerr", oerr, 0);
      check("midreset perr", perr, 0);
      rxd = 1'b1;
      repeat (5) @(negedge sysclk);
      rst_n = 1'b1;
      idle(2 * BIT);
      rx_frame(8'h0F, 1'b1, 0);
      check("post-reset rdata", rdata, 8'h0F);
      check("post-reset readyH", rxd_readyH, 1);
      ack_pulse();

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b1, 1'b0);
      idle(2 * BIT);
      check("parity good rdata", rdata, 8'h07);
      check("parity good perr", perr, 0);
      ack_pulse();
      send_frame(8'h07, 1'b1, 1'b0, 1'b0);
      idle(2 * BIT);
      check("parity bad perr", perr, 1);
      ack_pulse();
      check("parity ack perr", perr, 0);
`endif

      // randomized frames against a word-level handshake model
      m_ready = 1'b0; m_rdata = rdata; m_ferr = 1'b0; m_oerr = 1'b0; m_perr = 1'b0;
      for (int k = 0; k < 12; k++) begin
         rd      = 8'($urandom);
         rstop   = ($urandom_range(0, 3) != 0);
         perrbit = 1'($urandom_range(0, 1));
         repeat ($urandom_range(0, 40)) @(negedge sysclk);
         send_frame(rd, rstop, (^rd) ^ perrbit, 1'b0);
         if (!rstop) repeat ($urandom_range(0, 3) * BIT) @(negedge sysclk);
         idle(2 * BIT);
         if (!m_ready) begin
            m_ready = 1'b1;
            m_rdata = rd;
            m_ferr  = ~rstop;
            m_perr  = (NPAR == 1) ? perrbit : 1'b0;
         end else begin
            m_oerr = 1'b1;
         end
         check("rand rdata", rdata, m_rdata);
         check("rand readyH", rxd_readyH, m_ready);
         check("rand ferr", ferr, m_ferr);
         check("rand oerr", oerr, m_oerr);
         check("rand perr", perr, m_perr);
         if ($urandom_range(0, 1) == 1) begin
            ack_pulse();
            if (m_ready) begin
               m_ready = 1'b0; m_ferr = 1'b0; m_oerr = 1'b0; m_perr = 1'b0;
            end
            check("rand ack readyH", rxd_readyH, m_ready);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
